// File: rtl/cache_stage_one_pkg.sv
// Shared types for the cache front stage: pipe register layout, FSM states,
// field widths and the PLRU victim / request decode helpers.
package cache_types;

  localparam int TAG_W      = 23;
  localparam int IDX_W      = 4;
  localparam int OFF_W      = 5;
  localparam int DIRTY_BIT  = 23;
  localparam int NUM_WAYS   = 4;
  localparam int LINE_W     = 256;
  localparam int LINE_BYTES = 32;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
    logic [3:0]       ufp_rmask;
    logic [3:0]       ufp_wmask;
    logic [31:0]      ufp_wdata;
    logic             active;
  } pipe_reg_t;

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_WB     = 3'd1,
    S_REFILL = 3'd2,
    S_REPLAY = 3'd3,
    S_COMMIT = 3'd4
  } stage_one_state_t;

  // Tree PLRU: lru[2] picks the half, lru[1]/lru[0] pick the way within it.
  function automatic logic [1:0] plru_victim(input logic [2:0] lru);
    if (lru[2]) return lru[0] ? 2'd3 : 2'd2;
    else        return lru[1] ? 2'd1 : 2'd0;
  endfunction

  function automatic pipe_reg_t decode_req(input logic [31:0] addr,
                                           input logic [3:0]  rmask,
                                           input logic [3:0]  wmask,
                                           input logic [31:0] wdata);
    pipe_reg_t p;
    p.tag       = addr[31:9];
    p.index     = addr[8:5];
    p.offset    = addr[4:0];
    p.ufp_rmask = rmask;
    p.ufp_wmask = wmask;
    p.ufp_wdata = wdata;
    p.active    = |(rmask | wmask);
    return p;
  endfunction

endpackage

// File: rtl/cache_stage_one_if.sv
// CPU request, memory response and SRAM read-back bus seen by the cache front stage.
interface cache_stage_one_if;
  import cache_types::*;

  logic [31:0]         ufp_addr;
  logic [3:0]          ufp_rmask;
  logic [3:0]          ufp_wmask;
  logic [31:0]         ufp_wdata;
  logic                dfp_resp;
  logic [LINE_W-1:0]   dfp_rdata;
  // Registered SRAM reads for the set currently held in the pipe register.
  logic [2:0]          lru_dout;
  logic [NUM_WAYS-1:0] tag_dirty;
  logic [NUM_WAYS-1:0] valid_dout;

  modport master (
    output ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata,
    output dfp_resp, dfp_rdata,
    output lru_dout, tag_dirty, valid_dout
  );

  modport slave (
    input ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata,
    input dfp_resp, dfp_rdata,
    input lru_dout, tag_dirty, valid_dout
  );

endinterface

// File: rtl/cache_stage_one_wmask.sv
// Positions a 32-bit store into a 32-byte line: byte enables and shifted data.
// Bytes pushed past byte 31 fall off the end; nothing wraps.
module cache_wmask_expand
  import cache_types::*;
(
  input  logic [OFF_W-1:0]      offset_i,
  input  logic [3:0]            wmask_i,
  input  logic [31:0]           wdata_i,
  output logic [LINE_BYTES-1:0] byte_mask_o,
  output logic [LINE_W-1:0]     line_data_o
);

  always_comb begin
    byte_mask_o = LINE_BYTES'(wmask_i) << offset_i;
    line_data_o = LINE_W'(wdata_i) << {offset_i, 3'b000};
  end

endmodule

// File: rtl/cache_stage_one.sv
// Cache front stage: registers CPU requests, drives SRAM ports and sequences
// writeback, refill, replay and write-hit commit.
module cache_stage_one
  import cache_types::*;
#(
  parameter int WAYS      = 4,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_stage_one_if.slave        bus,
  input  logic                    stall,
  input  logic                    cache_hit,
  input  logic [1:0]              cache_hit_way,
  input  logic                    write_flag,
  input  logic [2:0]              lru_new,
  output pipe_reg_t               pipe_reg,
  output logic [$clog2(SETS)-1:0] sram_index,
  output logic [WAYS-1:0]         data_web,
  output logic [31:0]             data_wmask,
  output logic [LINE_BITS-1:0]    data_din,
  output logic [WAYS-1:0]         tag_web,
  output logic [TAG_W:0]          tag_din,
  output logic [WAYS-1:0]         valid_web,
  output logic                    lru_web,
  output logic [2:0]              lru_din,
  output logic                    response,
  output logic                    dirty_miss,
  output logic                    write_stall,
  output logic [1:0]              cache_replace_way
);

  stage_one_state_t state_q, state_d;
  pipe_reg_t        pipe_q, pipe_d;
  logic             resp_q, resp_d;
  logic             dmiss_q, dmiss_d;
  logic [1:0]       repl_way_q, repl_way_d;

  logic [1:0]            victim;
  logic                  victim_dirty;
  logic [LINE_BYTES-1:0] commit_mask;
  logic [LINE_W-1:0]     commit_data;

  cache_wmask_expand u_wmask (
    .offset_i    (pipe_q.offset),
    .wmask_i     (pipe_q.ufp_wmask),
    .wdata_i     (pipe_q.ufp_wdata),
    .byte_mask_o (commit_mask),
    .line_data_o (commit_data)
  );

  assign victim       = plru_victim(bus.lru_dout);
  assign victim_dirty = bus.tag_dirty[victim] & bus.valid_dout[victim];

  always_comb begin
    state_d     = state_q;
    pipe_d      = pipe_q;
    resp_d      = 1'b0;
    dmiss_d     = dmiss_q;
    repl_way_d  = repl_way_q;
    sram_index  = pipe_q.index;
    data_web    = '1;
    data_wmask  = '0;
    data_din    = '0;
    tag_web     = '1;
    tag_din     = '0;
    valid_web   = '1;
    lru_web     = 1'b1;
    lru_din     = lru_new;
    write_stall = 1'b0;

    unique case (state_q)
      S_RUN: begin
        // Miss handling takes priority over a pending write-hit commit.
        if (stall) begin
          repl_way_d = victim;
          state_d    = victim_dirty ? S_WB : S_REFILL;
        end else if (write_flag) begin
          state_d = S_COMMIT;
        end else begin
          sram_index = bus.ufp_addr[8:5];
          pipe_d     = decode_req(bus.ufp_addr, bus.ufp_rmask, bus.ufp_wmask, bus.ufp_wdata);
        end
      end
      S_WB: begin
        resp_d = bus.dfp_resp;
        if (bus.dfp_resp) begin
          dmiss_d = 1'b1;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        resp_d = bus.dfp_resp;
        if (bus.dfp_resp) begin
          data_web[repl_way_q]  = 1'b0;
          data_wmask            = '1;
          data_din              = bus.dfp_rdata;
          tag_din[TAG_W-1:0]    = pipe_q.tag;
          tag_din[DIRTY_BIT]    = 1'b0;
          tag_web[repl_way_q]   = 1'b0;
          valid_web[repl_way_q] = 1'b0;
          state_d               = S_REPLAY;
        end
      end
      S_REPLAY: begin
        write_stall = 1'b1;
        dmiss_d     = 1'b0;
        state_d     = S_RUN;
      end
      S_COMMIT: begin
        data_web[cache_hit_way] = 1'b0;
        data_wmask              = commit_mask;
        data_din                = commit_data;
        tag_din[TAG_W-1:0]      = pipe_q.tag;
        tag_din[DIRTY_BIT]      = 1'b1;
        tag_web[cache_hit_way]  = 1'b0;
        write_stall             = 1'b1;
        state_d                 = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    if (cache_hit && !stall && pipe_q.active) lru_web = 1'b0;

    // A reset cycle must never disturb array contents.
    if (!rst) begin
      data_web  = '1;
      tag_web   = '1;
      valid_web = '1;
      lru_web   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_RUN;
      pipe_q     <= '0;
      resp_q     <= 1'b0;
      dmiss_q    <= 1'b0;
      repl_way_q <= '0;
    end else begin
      state_q    <= state_d;
      pipe_q     <= pipe_d;
      resp_q     <= resp_d;
      dmiss_q    <= dmiss_d;
      repl_way_q <= repl_way_d;
    end
  end

  assign pipe_reg          = pipe_q;
  assign response          = resp_q;
  assign dirty_miss        = dmiss_q;
  assign cache_replace_way = repl_way_q;

endmodule

// File: tb/tb_cache_stage_one.sv
// Self-checking bench for cache_stage_one: directed miss/commit/reset scenarios
// plus randomized request and write-hit traffic against an arithmetic model.
module tb_cache_stage_one;
  import cache_types::*;

  logic clk = 1'b0;
  logic rst;
  logic stall, cache_hit, write_flag;
  logic [1:0] cache_hit_way;
  logic [2:0] lru_new;
  pipe_reg_t pipe_reg;
  logic [3:0] sram_index, data_web, tag_web, valid_web;
  logic [31:0] data_wmask;
  logic [255:0] data_din;
  logic [23:0] tag_din;
  logic lru_web;
  logic [2:0] lru_din;
  logic response, dirty_miss, write_stall;
  logic [1:0] cache_replace_way;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  cache_stage_one_if bus();

  cache_stage_one dut (
    .clk(clk), .rst(rst), .bus(bus), .stall(stall), .cache_hit(cache_hit),
    .cache_hit_way(cache_hit_way), .write_flag(write_flag), .lru_new(lru_new),
    .pipe_reg(pipe_reg), .sram_index(sram_index), .data_web(data_web),
    .data_wmask(data_wmask), .data_din(data_din), .tag_web(tag_web),
    .tag_din(tag_din), .valid_web(valid_web), .lru_web(lru_web),
    .lru_din(lru_din), .response(response), .dirty_miss(dirty_miss),
    .write_stall(write_stall), .cache_replace_way(cache_replace_way)
  );

  // Expected byte enables: byte (off+b) is written when wmask[b] is set and it fits in the line.
  function automatic logic [31:0] exp_mask(input int off, input logic [3:0] wm);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (wm[b] && (off + b) < 32) m[off + b] = 1'b1;
    return m;
  endfunction

  function automatic logic [255:0] exp_line(input int off, input logic [31:0] wd);
    logic [255:0] l;
    l = '0;
    for (int b = 0; b < 4; b++)
      if ((off + b) < 32) l[(off + b) * 8 +: 8] = wd[b * 8 +: 8];
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ufp_addr = '0; bus.ufp_rmask = '0; bus.ufp_wmask = '0; bus.ufp_wdata = '0;
    bus.dfp_resp = 1'b0; bus.dfp_rdata = '0;
    bus.lru_dout = '0; bus.tag_dirty = '0; bus.valid_dout = '0;
    stall = 1'b0; cache_hit = 1'b0; cache_hit_way = '0; write_flag = 1'b0; lru_new = '0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd);
    bus.ufp_addr = a; bus.ufp_rmask = rm; bus.ufp_wmask = wm; bus.ufp_wdata = wd;
    tick();
    bus.ufp_rmask = '0; bus.ufp_wmask = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0; stall = 1'b1; write_flag = 1'b1; bus.dfp_resp = 1'b1;
    tick();
    n_checks++; if (data_web !== 4'hF) begin n_fails++; $display("FAIL rst_data_web got=%h exp=f", data_web); end
    n_checks++; if (lru_web !== 1'b1) begin n_fails++; $display("FAIL rst_lru_web got=%b exp=1", lru_web); end
    tick();
    n_checks++; if (pipe_reg !== '0) begin n_fails++; $display("FAIL rst_pipe_reg got=%h exp=0", pipe_reg); end
    n_checks++; if (response !== 1'b0) begin n_fails++; $display("FAIL rst_response got=%b exp=0", response); end
    n_checks++; if (dirty_miss !== 1'b0) begin n_fails++; $display("FAIL rst_dirty_miss got=%b exp=0", dirty_miss); end
    n_checks++; if (write_stall !== 1'b0) begin n_fails++; $display("FAIL rst_write_stall got=%b exp=0", write_stall); end
    drive_idle();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read_decode();
    bus.ufp_addr = 32'h0000_1024; bus.ufp_rmask = 4'hF;
    #1;
    n_checks++; if (sram_index !== 4'd1) begin n_fails++; $display("FAIL rd_sram_index got=%0d exp=1", sram_index); end
    tick();
    bus.ufp_rmask = '0;
    n_checks++; if (pipe_reg.tag !== 23'h8) begin n_fails++; $display("FAIL rd_tag got=%h exp=8", pipe_reg.tag); end
    n_checks++; if (pipe_reg.index !== 4'd1) begin n_fails++; $display("FAIL rd_index got=%0d exp=1", pipe_reg.index); end
    n_checks++; if (pipe_reg.offset !== 5'd4) begin n_fails++; $display("FAIL rd_offset got=%0d exp=4", pipe_reg.offset); end
    n_checks++; if (pipe_reg.active !== 1'b1) begin n_fails++; $display("FAIL rd_active got=%b exp=1", pipe_reg.active); end
  endtask

  task automatic test_clean_miss();
    logic [255:0] rd;
    rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    issue(32'h0000_2040, 4'hF, 4'h0, 32'h0);
    bus.ufp_addr = 32'hFFFF_FFE0;
    stall = 1'b1; bus.lru_dout = 3'b000; bus.tag_dirty = 4'b1110; bus.valid_dout = 4'hF;
    #1;
    n_checks++; if (sram_index !== 4'd2) begin n_fails++; $display("FAIL cm_hold_index got=%0d exp=2", sram_index); end
    tick();
    bus.lru_dout = 3'b111;
    n_checks++; if (cache_replace_way !== 2'd0) begin n_fails++; $display("FAIL cm_victim got=%0d exp=0", cache_replace_way); end
    tick();
    n_checks++; if (data_web !== 4'hF) begin n_fails++; $display("FAIL cm_no_write_wait got=%h exp=f", data_web); end
    n_checks++; if (pipe_reg.tag !== 23'h10) begin n_fails++; $display("FAIL cm_pipe_hold got=%h exp=10", pipe_reg.tag); end
    bus.dfp_resp = 1'b1; bus.dfp_rdata = rd;
    #1;
    n_checks++; if (data_web !== 4'b1110) begin n_fails++; $display("FAIL cm_data_web got=%b exp=1110", data_web); end
    n_checks++; if (data_wmask !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL cm_wmask got=%h exp=ffffffff", data_wmask); end
    n_checks++; if (data_din !== rd) begin n_fails++; $display("FAIL cm_data_din got=%h exp=%h", data_din, rd); end
    n_checks++; if (tag_din !== {1'b0, 23'h10}) begin n_fails++; $display("FAIL cm_tag_din got=%h exp=000010", tag_din); end
    n_checks++; if (tag_web !== 4'b1110 || valid_web !== 4'b1110) begin n_fails++; $display("FAIL cm_tag_valid_web got=%b/%b exp=1110/1110", tag_web, valid_web); end
    tick();
    bus.dfp_resp = 1'b0; stall = 1'b0;
    n_checks++; if (response !== 1'b1) begin n_fails++; $display("FAIL cm_response got=%b exp=1", response); end
    n_checks++; if (write_stall !== 1'b1) begin n_fails++; $display("FAIL cm_replay_stall got=%b exp=1", write_stall); end
    n_checks++; if (sram_index !== 4'd2) begin n_fails++; $display("FAIL cm_replay_index got=%0d exp=2", sram_index); end
    tick();
    n_checks++; if (response !== 1'b0) begin n_fails++; $display("FAIL cm_response_pulse got=%b exp=0", response); end
    n_checks++; if (write_stall !== 1'b0) begin n_fails++; $display("FAIL cm_replay_len got=%b exp=0", write_stall); end
    issue(32'h0000_3060, 4'hF, 4'h0, 32'h0);
    n_checks++; if (pipe_reg.tag !== 23'h18) begin n_fails++; $display("FAIL cm_back_to_run got=%h exp=18", pipe_reg.tag); end
  endtask

  task automatic test_dirty_miss();
    issue(32'h0001_0060, 4'hF, 4'h0, 32'h0);
    stall = 1'b1; bus.lru_dout = 3'b101; bus.tag_dirty = 4'b1000; bus.valid_dout = 4'hF;
    tick();
    n_checks++; if (cache_replace_way !== 2'd3) begin n_fails++; $display("FAIL dm_victim got=%0d exp=3", cache_replace_way); end
    bus.dfp_resp = 1'b1;
    #1;
    n_checks++; if (data_web !== 4'hF) begin n_fails++; $display("FAIL dm_wb_no_write got=%h exp=f", data_web); end
    tick();
    bus.dfp_resp = 1'b0;
    n_checks++; if (dirty_miss !== 1'b1) begin n_fails++; $display("FAIL dm_dirty_set got=%b exp=1", dirty_miss); end
    n_checks++; if (response !== 1'b1) begin n_fails++; $display("FAIL dm_wb_response got=%b exp=1", response); end
    tick();
    n_checks++; if (response !== 1'b0) begin n_fails++; $display("FAIL dm_resp_pulse got=%b exp=0", response); end
    bus.dfp_resp = 1'b1; bus.dfp_rdata = {8{32'h5A5A_0F0F}};
    #1;
    n_checks++; if (data_web !== 4'b0111 || valid_web !== 4'b0111) begin n_fails++; $display("FAIL dm_refill_web got=%b/%b exp=0111/0111", data_web, valid_web); end
    n_checks++; if (tag_din !== {1'b0, 23'h80}) begin n_fails++; $display("FAIL dm_tag_din got=%h exp=000080", tag_din); end
    tick();
    bus.dfp_resp = 1'b0; stall = 1'b0;
    n_checks++; if (write_stall !== 1'b1 || dirty_miss !== 1'b1) begin n_fails++; $display("FAIL dm_replay got=%b/%b exp=1/1", write_stall, dirty_miss); end
    tick();
    n_checks++; if (dirty_miss !== 1'b0) begin n_fails++; $display("FAIL dm_dirty_clear got=%b exp=0", dirty_miss); end
  endtask

  task automatic test_write_hit();
    issue({23'h123, 4'd5, 5'd8}, 4'h0, 4'b0011, 32'hAABB_CCDD);
    bus.ufp_addr = 32'h0; bus.ufp_wdata = 32'h0; write_flag = 1'b1;
    #1;
    n_checks++; if (sram_index !== 4'd5) begin n_fails++; $display("FAIL wh_index got=%0d exp=5", sram_index); end
    tick();
    write_flag = 1'b0; cache_hit_way = 2'd2;
    #1;
    n_checks++; if (data_web !== 4'b1011) begin n_fails++; $display("FAIL wh_data_web got=%b exp=1011", data_web); end
    n_checks++; if (data_wmask !== 32'h0000_0300) begin n_fails++; $display("FAIL wh_wmask got=%h exp=00000300", data_wmask); end
    n_checks++; if (data_din[79:64] !== 16'hCCDD) begin n_fails++; $display("FAIL wh_bytes8_9 got=%h exp=ccdd", data_din[79:64]); end
    n_checks++; if (data_din !== exp_line(8, 32'hAABB_CCDD)) begin n_fails++; $display("FAIL wh_data_din got=%h", data_din); end
    n_checks++; if (tag_web !== 4'b1011 || tag_din !== {1'b1, 23'h123}) begin n_fails++; $display("FAIL wh_tag got=%b/%h exp=1011/800123", tag_web, tag_din); end
    n_checks++; if (write_stall !== 1'b1) begin n_fails++; $display("FAIL wh_stall got=%b exp=1", write_stall); end
    tick();
    n_checks++; if (write_stall !== 1'b0) begin n_fails++; $display("FAIL wh_stall_len got=%b exp=0", write_stall); end
    n_checks++; if (pipe_reg.tag !== 23'h123) begin n_fails++; $display("FAIL wh_no_load got=%h exp=123", pipe_reg.tag); end
    issue({23'h55, 4'd9, 5'd30}, 4'h0, 4'hF, 32'h1122_3344);
    write_flag = 1'b1;
    tick();
    write_flag = 1'b0; cache_hit_way = 2'd1;
    #1;
    n_checks++; if (data_wmask !== 32'hC000_0000) begin n_fails++; $display("FAIL wh_trunc_mask got=%h exp=c0000000", data_wmask); end
    n_checks++; if (data_din !== exp_line(30, 32'h1122_3344)) begin n_fails++; $display("FAIL wh_trunc_din got=%h", data_din); end
    n_checks++; if (data_web !== 4'b1101) begin n_fails++; $display("FAIL wh_trunc_web got=%b exp=1101", data_web); end
    tick();
  endtask

  task automatic test_stall_beats_write();
    issue(32'h0000_4080, 4'hF, 4'h0, 32'h0);
    stall = 1'b1; write_flag = 1'b1; bus.lru_dout = 3'b010; bus.tag_dirty = 4'h0; bus.valid_dout = 4'hF;
    tick();
    write_flag = 1'b0;
    #1;
    n_checks++; if (write_stall !== 1'b0 || data_web !== 4'hF) begin n_fails++; $display("FAIL sw_not_commit got=%b/%h exp=0/f", write_stall, data_web); end
    n_checks++; if (cache_replace_way !== 2'd1) begin n_fails++; $display("FAIL sw_victim got=%0d exp=1", cache_replace_way); end
    bus.dfp_resp = 1'b1;
    #1;
    n_checks++; if (data_web !== 4'b1101) begin n_fails++; $display("FAIL sw_refill_web got=%b exp=1101", data_web); end
    tick();
    bus.dfp_resp = 1'b0; stall = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_miss();
    issue(32'h0000_2040, 4'hF, 4'h0, 32'h0);
    stall = 1'b1; bus.lru_dout = 3'b000; bus.tag_dirty = 4'h0; bus.valid_dout = 4'hF;
    tick();
    rst = 1'b0; bus.dfp_resp = 1'b1; stall = 1'b0; cache_hit = 1'b1;
    #1;
    n_checks++; if (data_web !== 4'hF || tag_web !== 4'hF || valid_web !== 4'hF) begin n_fails++; $display("FAIL rm_web got=%h/%h/%h exp=f/f/f", data_web, tag_web, valid_web); end
    n_checks++; if (lru_web !== 1'b1) begin n_fails++; $display("FAIL rm_lru_web got=%b exp=1", lru_web); end
    tick();
    rst = 1'b1; bus.dfp_resp = 1'b0; cache_hit = 1'b0;
    n_checks++; if (response !== 1'b0 || write_stall !== 1'b0) begin n_fails++; $display("FAIL rm_outputs got=%b/%b exp=0/0", response, write_stall); end
    n_checks++; if (pipe_reg !== '0) begin n_fails++; $display("FAIL rm_pipe got=%h exp=0", pipe_reg); end
    issue(32'h0000_3060, 4'hF, 4'h0, 32'h0);
    n_checks++; if (pipe_reg.tag !== 23'h18 || write_stall !== 1'b0) begin n_fails++; $display("FAIL rm_run got=%h/%b exp=18/0", pipe_reg.tag, write_stall); end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd;
    logic [3:0] rm, wm;
    logic [22:0] m_tag;
    logic [3:0] m_idx, m_wm;
    logic [31:0] m_wd;
    int m_off, op, hw;
    bit m_active;
    // Pipe currently holds the 0x3060 read left by the previous scenario.
    m_tag = 23'h18; m_idx = 4'd3; m_off = 0; m_wm = 4'h0; m_wd = 32'h0; m_active = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 3);
      cache_hit = 1'($urandom); lru_new = 3'($urandom); bus.dfp_resp = 1'($urandom);
      if (op != 3) begin
        addr = $urandom; wd = $urandom;
        rm = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        wm = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        bus.ufp_addr = addr; bus.ufp_rmask = rm; bus.ufp_wmask = wm; bus.ufp_wdata = wd;
        #1;
        n_checks++; if (sram_index !== 4'((addr / 32) % 16)) begin n_fails++; $display("FAIL rnd_sram_index got=%0d addr=%h", sram_index, addr); end
        n_checks++; if (lru_web !== !(cache_hit && m_active)) begin n_fails++; $display("FAIL rnd_lru_web got=%b exp=%b", lru_web, !(cache_hit && m_active)); end
        if (!lru_web) begin
          n_checks++; if (lru_din !== lru_new) begin n_fails++; $display("FAIL rnd_lru_din got=%b exp=%b", lru_din, lru_new); end
        end
        n_checks++; if (data_web !== 4'hF || tag_web !== 4'hF) begin n_fails++; $display("FAIL rnd_run_web got=%h/%h exp=f/f", data_web, tag_web); end
        tick();
        m_tag = 23'(addr / 512); m_idx = 4'((addr / 32) % 16); m_off = int'(addr % 32);
        m_wm = wm; m_wd = wd; m_active = (rm != 0) || (wm != 0);
        n_checks++; if (pipe_reg.tag !== m_tag || pipe_reg.index !== m_idx || pipe_reg.offset !== 5'(m_off)) begin n_fails++; $display("FAIL rnd_decode got=%h/%h/%h addr=%h", pipe_reg.tag, pipe_reg.index, pipe_reg.offset, addr); end
        n_checks++; if (pipe_reg.active !== m_active || pipe_reg.ufp_rmask !== rm || pipe_reg.ufp_wmask !== wm || pipe_reg.ufp_wdata !== wd) begin n_fails++; $display("FAIL rnd_payload got=%b/%h/%h/%h", pipe_reg.active, pipe_reg.ufp_rmask, pipe_reg.ufp_wmask, pipe_reg.ufp_wdata); end
        n_checks++; if (response !== 1'b0) begin n_fails++; $display("FAIL rnd_resp_ignored got=%b exp=0", response); end
      end else begin
        bus.ufp_addr = $urandom; write_flag = 1'b1;
        #1;
        n_checks++; if (sram_index !== m_idx) begin n_fails++; $display("FAIL rnd_wf_index got=%0d exp=%0d", sram_index, m_idx); end
        tick();
        hw = $urandom_range(0, 3);
        write_flag = 1'b0; cache_hit_way = 2'(hw); cache_hit = 1'($urandom); bus.dfp_resp = 1'($urandom);
        #1;
        n_checks++; if (data_web !== ~(4'b0001 << hw) || tag_web !== ~(4'b0001 << hw)) begin n_fails++; $display("FAIL rnd_commit_web got=%b/%b way=%0d", data_web, tag_web, hw); end
        n_checks++; if (data_wmask !== exp_mask(m_off, m_wm)) begin n_fails++; $display("FAIL rnd_commit_mask got=%h exp=%h", data_wmask, exp_mask(m_off, m_wm)); end
        n_checks++; if (data_din !== exp_line(m_off, m_wd)) begin n_fails++; $display("FAIL rnd_commit_din got=%h exp=%h", data_din, exp_line(m_off, m_wd)); end
        n_checks++; if (tag_din !== {1'b1, m_tag} || write_stall !== 1'b1) begin n_fails++; $display("FAIL rnd_commit_tag got=%h/%b exp=%h/1", tag_din, write_stall, {1'b1, m_tag}); end
        n_checks++; if (lru_web !== !(cache_hit && m_active)) begin n_fails++; $display("FAIL rnd_commit_lru got=%b exp=%b", lru_web, !(cache_hit && m_active)); end
        tick();
        n_checks++; if (write_stall !== 1'b0 || response !== 1'b0 || pipe_reg.tag !== m_tag) begin n_fails++; $display("FAIL rnd_post_commit got=%b/%b/%h exp=0/0/%h", write_stall, response, pipe_reg.tag, m_tag); end
      end
    end
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    rst = 1'b0;
    test_reset();
    test_read_decode();
    test_clean_miss();
    test_dirty_miss();
    test_write_hit();
    test_stall_beats_write();
    test_reset_mid_miss();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cache_stage_one.md
Name: cache_stage_one

Overview:
- Front stage of the 4-way, 16-set, 32-byte-line pipelined cache. Sits directly upstream of the tag-compare/hit stage.
- Accepts CPU (ufp) requests and decodes them into the cache_types pipe register.
- Drives the data/tag/valid/LRU SRAM ports and sequences miss handling: writeback, refill, replay and the write-hit commit stall.
- Produces the response, dirty_miss, write_stall and cache_replace_way inputs that the compare stage consumes.

Parameters:
- WAYS, 4, associativity; PLRU decode is fixed at 3 bits, so only 4 is supported.
- SETS, 16, number of sets; index width is 4.
- LINE_BITS, 256, cache line width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (reset when rst==0 at posedge clk)
- ufp_addr  in  32  CPU request address
- ufp_rmask  in  4  read byte mask
- ufp_wmask  in  4  write byte mask
- ufp_wdata  in  32  write data
- stall  in  1  miss stall from the compare stage
- cache_hit  in  1  hit from the compare stage
- cache_hit_way  in  2  hit way
- write_flag  in  1  write hit commit request
- lru_new  in  3  updated PLRU bits
- dfp_resp  in  1  memory response
- dfp_rdata  in  256  refill line
- pipe_reg  out  pipe_reg_t  registered request (tag[22:0], index[3:0], offset[4:0], ufp_rmask, ufp_wmask, ufp_wdata, active)
- sram_index  out  4  shared read/write set index for all arrays
- data_web  out  4  per-way data write enable, active-low
- data_wmask  out  32  byte enables for the data write
- data_din  out  256  data write value
- tag_web  out  4  per-way tag write enable, active-low
- tag_din  out  24  {dirty, tag[22:0]}
- valid_web  out  4  per-way valid write enable, active-low
- lru_web  out  1  LRU write enable, active-low
- lru_din  out  3  LRU write value
- response  out  1  registered dfp_resp
- dirty_miss  out  1  writeback done, refill in progress
- write_stall  out  1  commit/replay bubble
- cache_replace_way  out  2  victim way

Behaviour:
- Reset values:
  - pipe_reg all-zero, active=0.
  - FSM in RUN.
  - response, dirty_miss and write_stall all 0.
  - All web signals 1 (no writes).
- FSM states: RUN, WB, REFILL, REPLAY, COMMIT.
- RUN:
  - If stall==0 and write_flag==0: pipe_reg <= decode(ufp_addr): tag=[31:9], index=[8:5], offset=[4:0]. Masks and wdata are copied; active <= (rmask|wmask)!=0.
  - sram_index = ufp_addr[8:5], so the SRAM read output lines up with the pipe_reg update, giving 1-cycle read latency.
  - stall==1: pipe_reg holds and sram_index = pipe_reg.index. Go to WB if the victim tag[23]&valid, else REFILL.
  - write_flag==1: go to COMMIT.
- WB: hold pipe_reg. On dfp_resp: dirty_miss <= 1, go to REFILL.
- REFILL: on dfp_resp:
  - data_web[victim]=0, data_wmask=all ones, data_din=dfp_rdata.
  - tag_din={0, pipe_reg.tag}, tag_web[victim]=0, valid_web[victim]=0.
  - Go to REPLAY.
- response is dfp_resp delayed one cycle, a 1-cycle pulse. It is asserted in both WB and REFILL.
- REPLAY: one cycle re-reading pipe_reg.index. write_stall=1, dirty_miss <= 0. Return to RUN; the compare stage now hits.
- COMMIT:
  - data_web[cache_hit_way]=0.
  - data_wmask = ufp_wmask shifted left by offset (byte granularity), data_din = ufp_wdata placed at byte offset.
  - tag_din={1, tag}, tag_web[hit_way]=0 to set the dirty bit.
  - write_stall=1 for exactly one cycle, then return to RUN without loading a new request that cycle.
- LRU:
  - lru_web=0, lru_din=lru_new at pipe_reg.index whenever cache_hit & !stall & pipe_reg.active.
  - A simultaneous LRU write and data write is legal (separate array).
- Victim decode from the registered LRU read (lru):
  - lru[2]=1: way 3 if lru[0] else way 2.
  - lru[2]=0: way 1 if lru[1] else way 0.
  - Latched at the RUN→WB/REFILL transition; held until RUN.
- Boundary conditions:
  - offset is word-aligned. A misaligned offset with wmask crossing byte 31 is truncated; there is no wrap.
  - dfp_resp outside WB/REFILL is ignored.
  - An idle request (both masks 0) keeps active=0 and never triggers a miss.
  - stall and write_flag together: stall wins.
  - Reset mid-miss: immediate return to RUN, outputs to reset values, no SRAM write that cycle.

Decomposition:
- cache_types package:
  - pipe_reg_t
  - stage_one_state_t enum
  - TAG_W=23, IDX_W=4, OFF_W=5
  - DIRTY_BIT=23
  - plru_victim() function
- Sub-module cache_wmask_expand: converts (offset, wmask, wdata) into the 32-bit byte mask and the 256-bit positioned data.

Test Plan:
- Reset, then read 0x0000_1024 rmask=F: pipe_reg tag=0x000008, index=1, offset=4, active=1 one cycle later. sram_index=1 in the request cycle.
- Clean miss, victim lru=3'b000 → way0: REFILL, and on dfp_resp the line is written to way0 with tag_din dirty=0.
- Clean miss continued: response pulses 1 cycle, then REPLAY with write_stall=1 for 1 cycle, then RUN.
- Dirty miss, lru=3'b101 → way3 with dirty set: WB, dfp_resp → dirty_miss=1, REFILL, dfp_resp → refill way3, dirty_miss back to 0 after REPLAY.
- Write hit way2, offset 8, wmask 4'b0011, wdata 0xAABBCCDD: COMMIT with data_wmask=0x0000_0300, data_din bytes 8..9 = DD,CC, tag_web[2]=0 with dirty=1, write_stall=1 for 1 cycle.
- Reset (rst=0) asserted in REFILL with dfp_resp=1 the same cycle: no web asserted, state RUN, response=0.
